// File: rtl/irq_daisy_chain.sv
// Interrupt controller: fixed-priority daisy chain over N_SRC lines, irq_req/irq_ret handshake with the core.
// Optional build macro IRQ_EDGE_EN selects rising-edge pending latches; default is level-sensitive.
module irq_daisy_chain #(
    parameter int unsigned N_SRC      = 16,
    parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] irq_i,
    input  logic [N_SRC-1:0] mask_i,
    input  logic             irq_ret_i,
    output logic             irq_req_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_SRC-1:0] irq_ack_o
);

    localparam int unsigned CAUSE_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [N_SRC-1:0]   grant;
    logic [N_SRC-1:0]   grant_next;
    logic [N_SRC-1:0]   ack_next;
    logic [N_SRC-1:0]   pend_now;
    logic [N_SRC-1:0]   elig;
    logic [N_SRC-1:0]   gnt_c;
    logic [N_SRC:0]     chain;
    logic               req_next;
    logic [CAUSE_W-1:0] cause_next;
    logic [CAUSE_W-1:0] cause_sel;

`ifdef IRQ_EDGE_EN
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] hist;
    logic [N_SRC-1:0] rise;

    assign rise     = irq_i & ~hist & mask_i;
    // A rise in this cycle is already visible, so both builds share the same request latency.
    assign pend_now = pend | rise;

    // Clear on entry to ACK; a simultaneous new edge wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend <= '0;
            hist <= '0;
        end else begin
            pend <= (pend & ~ack_next) | rise;
            hist <= irq_i;
        end
    end
`else
    assign pend_now = irq_i & mask_i;
`endif

    assign elig = pend_now & mask_i;

    // Ripple priority chain, index 0 highest; cause encoded from the one-hot winner.
    always_comb begin
        chain[0]  = 1'b1;
        gnt_c     = '0;
        cause_sel = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            gnt_c[k]   = chain[k] & elig[k];
            chain[k+1] = chain[k] & ~elig[k];
            if (gnt_c[k]) begin
                cause_sel = CAUSE_BASE + CAUSE_W'(k);
            end
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        req_next   = irq_req_o;
        cause_next = irq_cause_o;
        ack_next   = '0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_next = ACTIVE;
                    grant_next = gnt_c;
                    req_next   = 1'b1;
                    cause_next = cause_sel;
                end
            end
            ACTIVE: begin
                if (irq_ret_i) begin
                    state_next = ACK;
                    ack_next   = grant;
                    grant_next = '0;
                    req_next   = 1'b0;
                    cause_next = '0;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                req_next   = 1'b0;
                cause_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            grant       <= '0;
            irq_req_o   <= 1'b0;
            irq_cause_o <= '0;
            irq_ack_o   <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            irq_req_o   <= req_next;
            irq_cause_o <= cause_next;
            irq_ack_o   <= ack_next;
        end
    end

endmodule
